// File: rtl/led_bank_sched.sv
// led_bank_sched: round-robin word writer for an enable-FF LED bank, with a shadow copy,
// a power-on clear sweep and a lamp-test sequence (all on, hold, restore).
module led_bank_sched #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH = 8,
  parameter int NUM_WORDS = 4,
  parameter int LAMP_CYCLES = 1024,
  localparam int AW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*AW-1:0]    req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  input  logic                     lamp_req_i,
  output logic [NUM_WORDS-1:0]     en_o,
  output logic [WIDTH-1:0]         d_o,
  output logic                     busy_o
);
  localparam int HW = $clog2(LAMP_CYCLES + 1);
  localparam int RW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [AW-1:0] LAST_W = AW'(NUM_WORDS - 1);
  localparam logic [HW-1:0] LAST_H = HW'(LAMP_CYCLES - 1);
  typedef enum logic [2:0] {INIT, IDLE, LAMP_SET, LAMP_HOLD, LAMP_RESTORE} state_t;
  state_t state, state_n;
  logic [AW-1:0] cnt, cnt_n, addr;
  logic [HW-1:0] hold, hold_n;
  logic [RW-1:0] last, g, r;
  logic [WIDTH-1:0] data, d_n;
  logic [NUM_WORDS-1:0] en_n;
  logic [WIDTH-1:0] shadow [NUM_WORDS];
  logic found, fire, in_range;
  always_comb begin
    found = 1'b0;
    g = last;
    r = last;
    for (int i = 0; i < NUM_REQ; i++) begin
      r = (r == RW'(NUM_REQ - 1)) ? '0 : r + 1'b1;
      if (!found && req_valid_i[r]) begin
        found = 1'b1;
        g = r;
      end
    end
    addr = '0;
    data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g == RW'(i)) begin
        addr = req_addr_i[i*AW +: AW];
        data = req_data_i[i*WIDTH +: WIDTH];
      end
    end
  end
  assign fire = state == IDLE && !lamp_req_i && found;
  assign in_range = {1'b0, addr} < (AW + 1)'(NUM_WORDS);
  assign req_ready_o = fire ? NUM_REQ'(1) << g : '0;
  assign busy_o = state != IDLE;
  // en_o/d_o are loaded with the value belonging to the next state, so the
  // state register and the bank strobe stay cycle-aligned.
  always_comb begin
    state_n = state;
    cnt_n = '0;
    hold_n = '0;
    en_n = '0;
    d_n = d_o;
    case (state)
      INIT: begin
        // en_o is zero only in the first cycle after reset: start the sweep at word 0
        if (en_o != '0 && cnt == LAST_W) state_n = IDLE;
        else begin
          cnt_n = (en_o == '0) ? '0 : cnt + 1'b1;
          en_n = NUM_WORDS'(1) << cnt_n;
          d_n = '0;
        end
      end
      IDLE: begin
        if (lamp_req_i) begin
          state_n = LAMP_SET;
          en_n = NUM_WORDS'(1);
          d_n = '1;
        end else if (fire) begin
          en_n = in_range ? NUM_WORDS'(1) << addr : '0;
          d_n = in_range ? data : d_o;
        end
      end
      LAMP_SET: begin
        if (cnt == LAST_W) state_n = LAMP_HOLD;
        else begin
          cnt_n = cnt + 1'b1;
          en_n = NUM_WORDS'(1) << cnt_n;
          d_n = '1;
        end
      end
      LAMP_HOLD: begin
        if (hold == LAST_H) begin
          state_n = LAMP_RESTORE;
          en_n = NUM_WORDS'(1);
          d_n = shadow[0];
        end else hold_n = hold + 1'b1;
      end
      LAMP_RESTORE: begin
        if (cnt == LAST_W) state_n = IDLE;
        else begin
          cnt_n = cnt + 1'b1;
          en_n = NUM_WORDS'(1) << cnt_n;
          d_n = shadow[cnt_n];
        end
      end
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= INIT;
      cnt <= '0;
      hold <= '0;
      last <= RW'(NUM_REQ - 1);
      en_o <= '0;
      d_o <= '0;
      for (int w = 0; w < NUM_WORDS; w++) shadow[w] <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hold <= hold_n;
      en_o <= en_n;
      d_o <= d_n;
      if (fire) begin
        last <= g;
        if (in_range) shadow[addr] <= data;
      end
    end
  end
endmodule

// File: tb/tb_led_bank_sched.sv
// tb_led_bank_sched: directed scoreboard bench; expected bank writes are queued by the stimulus
// and a negedge monitor pops them whenever a DUT drives a non-zero enable.
module tb_led_bank_sched;
  localparam int NR = 2, W = 8, NW = 4, LC = 5, NW2 = 5, LC2 = 1;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [NR-1:0] v = '0, rdy, v2 = '0, rdy2;
  logic [NR*2-1:0] addr = '0;
  logic [NR*3-1:0] addr2 = '0;
  logic [NR*W-1:0] data = '0, data2 = '0;
  logic lamp = 0, lamp2 = 0, busy, busy2;
  logic [NW-1:0] en;
  logic [NW2-1:0] en2;
  logic [W-1:0] d, d2;
  int cyc = 0, errors = 0, checks = 0, t;
  typedef struct {int c; int en; int d;} wr_t;
  typedef struct {bit v0; int a0; int d0; bit v1; int a1; int d1; int rdy;} vec_t;
  wr_t q[$], q2[$], e, e2;
  vec_t tv[8];
  logic [W-1:0] bank [NW];
  int shadow [NW];
  int sh2 [NW2];

  led_bank_sched #(.NUM_REQ(NR), .WIDTH(W), .NUM_WORDS(NW), .LAMP_CYCLES(LC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v), .req_ready_o(rdy), .req_addr_i(addr),
    .req_data_i(data), .lamp_req_i(lamp), .en_o(en), .d_o(d), .busy_o(busy));
  led_bank_sched #(.NUM_REQ(NR), .WIDTH(W), .NUM_WORDS(NW2), .LAMP_CYCLES(LC2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v2), .req_ready_o(rdy2), .req_addr_i(addr2),
    .req_data_i(data2), .lamp_req_i(lamp2), .en_o(en2), .d_o(d2), .busy_o(busy2));

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) for (int w = 0; w < NW; w++) if (en[w]) bank[w] <= d;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en != '0) begin
      if (q.size() == 0) chk("unexpected write", int'(en), 0);
      else begin
        e = q.pop_front();
        chk("write cycle", cyc, e.c);
        chk("write en", int'(en), e.en);
        chk("write d", int'(d), e.d);
      end
    end
    if (en2 != '0) begin
      if (q2.size() == 0) chk("unexpected write2", int'(en2), 0);
      else begin
        e2 = q2.pop_front();
        chk("write2 cycle", cyc, e2.c);
        chk("write2 en", int'(en2), e2.en);
        chk("write2 d", int'(d2), e2.d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int c, int en_v, int d_v);
    q.push_back('{c, en_v, d_v});
  endtask

  task automatic push2(int c, int en_v, int d_v);
    q2.push_back('{c, en_v, d_v});
  endtask

  task automatic drive(bit v0, int a0, int d0, bit v1, int a1, int d1);
    v = {v1, v0};
    addr = {2'(a1), 2'(a0)};
    data = {8'(d1), 8'(d0)};
  endtask

  task automatic drive2(bit v0, int a0, int d0, bit v1, int a1, int d1);
    v2 = {v1, v0};
    addr2 = {3'(a1), 3'(a0)};
    data2 = {8'(d1), 8'(d0)};
  endtask

  task automatic lamp_push(int c);
    for (int k = 0; k < NW; k++) push(c + 1 + k, 1 << k, 'hFF);
    for (int k = 0; k < NW; k++) push(c + 1 + NW + LC + k, 1 << k, shadow[k]);
  endtask

  task automatic do_reset();
    rst_n = 0;
    v = '0;
    v2 = '0;
    lamp = 0;
    lamp2 = 0;
    @(negedge clk);
    chk("rst en", int'(en), 0);
    chk("rst d", int'(d), 0);
    chk("rst ready", int'(rdy), 0);
    chk("rst busy", int'(busy), 1);
    chk("rst en2", int'(en2), 0);
    step();
    rst_n = 1;
    for (int k = 1; k <= NW; k++) push(cyc + k, 1 << (k - 1), 0);
    for (int k = 1; k <= NW2; k++) push2(cyc + k, 1 << (k - 1), 0);
    for (int k = 0; k < NW; k++) shadow[k] = 0;
    for (int k = 1; k <= NW2 + 1; k++) begin
      step();
      @(negedge clk);
      chk("init busy", int'(busy), int'(k <= NW));
      chk("init busy2", int'(busy2), int'(k <= NW2));
    end
    for (int k = 0; k < NW; k++) chk("bank cleared", int'(bank[k]), 0);
  endtask

  initial begin
    tv = '{'{1, 0, 'h10, 1, 3, 'h31, 1}, '{1, 1, 'h12, 1, 3, 'h31, 2},
           '{1, 1, 'h12, 1, 2, 'h33, 1}, '{1, 0, 'h14, 1, 2, 'h33, 2},
           '{0, 0, 0, 0, 0, 0, 0},        '{1, 2, 'hA5, 0, 0, 0, 1},
           '{0, 0, 0, 0, 0, 0, 0},        '{0, 0, 0, 1, 1, 'h3C, 2}};
    do_reset();
    // round-robin traffic and single writes
    foreach (tv[i]) begin
      step();
      drive(tv[i].v0, tv[i].a0, tv[i].d0, tv[i].v1, tv[i].a1, tv[i].d1);
      @(negedge clk);
      chk("grant", int'(rdy), tv[i].rdy);
      if (tv[i].rdy == 1) begin
        push(cyc + 1, 1 << tv[i].a0, tv[i].d0);
        shadow[tv[i].a0] = tv[i].d0;
      end
      if (tv[i].rdy == 2) begin
        push(cyc + 1, 1 << tv[i].a1, tv[i].d1);
        shadow[tv[i].a1] = tv[i].d1;
      end
    end
    // lamp test with a competing request held through it; a second pulse in HOLD is ignored
    step();
    drive(1, 3, 'h77, 0, 0, 0);
    lamp = 1;
    @(negedge clk);
    chk("lamp ready", int'(rdy), 0);
    chk("lamp idle busy", int'(busy), 0);
    t = cyc;
    lamp_push(t);
    for (int k = 1; k <= 2 * NW + LC; k++) begin
      step();
      lamp = (k == NW + 2);
      @(negedge clk);
      chk("lamp busy", int'(busy), 1);
      chk("lamp blocks ready", int'(rdy), 0);
      if (k == NW + LC) for (int w = 0; w < NW; w++) chk("bank all on", int'(bank[w]), 'hFF);
    end
    step();
    lamp = 0;
    @(negedge clk);
    chk("after lamp busy", int'(busy), 0);
    chk("after lamp ready", int'(rdy), 1);
    push(cyc + 1, 1 << 3, 'h77);
    shadow[3] = 'h77;
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    for (int w = 0; w < NW; w++) chk("bank restored", int'(bank[w]), shadow[w]);
    // reset asserted during LAMP_HOLD
    step();
    lamp = 1;
    @(negedge clk);
    t = cyc;
    for (int k = 0; k < NW; k++) push(t + 1 + k, 1 << k, 'hFF);
    step();
    lamp = 0;
    repeat (5) step();
    do_reset();
    step();
    drive(1, 0, 'h5A, 1, 1, 'h6B);
    @(negedge clk);
    chk("post-reset grant", int'(rdy), 1);
    push(cyc + 1, 1, 'h5A);
    shadow[0] = 'h5A;
    step();
    drive(0, 0, 0, 1, 1, 'h6B);
    @(negedge clk);
    chk("post-reset grant1", int'(rdy), 2);
    push(cyc + 1, 1 << 1, 'h6B);
    shadow[1] = 'h6B;
    step();
    drive(0, 0, 0, 0, 0, 0);
    lamp = 1;
    @(negedge clk);
    lamp_push(cyc);
    step();
    lamp = 0;
    repeat (2 * NW + LC) step();
    @(negedge clk);
    chk("second lamp done", int'(busy), 0);
    // out-of-range address on the 5-word instance
    step();
    drive2(1, 7, 'hEE, 0, 0, 0);
    @(negedge clk);
    chk("oor ready", int'(rdy2), 1);
    step();
    drive2(1, 4, 'h55, 1, 0, 'h66);
    @(negedge clk);
    chk("oor en", int'(en2), 0);
    chk("oor ptr advance", int'(rdy2), 2);
    push2(cyc + 1, 1, 'h66);
    step();
    drive2(1, 4, 'h55, 0, 0, 0);
    @(negedge clk);
    chk("oor next grant", int'(rdy2), 1);
    push2(cyc + 1, 1 << 4, 'h55);
    step();
    drive2(0, 0, 0, 0, 0, 0);
    lamp2 = 1;
    @(negedge clk);
    t = cyc;
    sh2 = '{'h66, 0, 0, 0, 'h55};
    for (int k = 0; k < NW2; k++) push2(t + 1 + k, 1 << k, 'hFF);
    for (int k = 0; k < NW2; k++) push2(t + 1 + NW2 + LC2 + k, 1 << k, sh2[k]);
    for (int k = 1; k <= 2 * NW2 + LC2; k++) begin
      step();
      lamp2 = 0;
      @(negedge clk);
      chk("lamp2 busy", int'(busy2), 1);
    end
    step();
    @(negedge clk);
    chk("lamp2 done", int'(busy2), 0);
    step();
    chk("queue drained", q.size(), 0);
    chk("queue2 drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
